// File: rtl/fir_axil_ctrl.sv
// rtl/fir_axil_ctrl.sv - AXI-lite control/status slave and tap SRAM arbiter for the FIR engine
module fir_axil_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  output logic                   awready,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wready,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   ap_start,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length,
  output logic [pDATA_WIDTH-1:0] tap_num
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_DLEN = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TNUM = pADDR_WIDTH'(20);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(128);
  localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(128 + 4 * Tape_Num);
  localparam logic [pDATA_WIDTH-1:0] TAP_MAX   = pDATA_WIDTH'(Tape_Num);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {C_IDLE, C_START, C_BUSY} c_state_e;

  w_state_e               w_state_q, w_state_d;
  r_state_e               r_state_q, r_state_d;
  c_state_e               c_state_q, c_state_d;
  logic [pADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                   tap_rd_q, tap_rd_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;
  logic [pDATA_WIDTH-1:0] tap_num_q, tap_num_d;
  logic                   ap_done_q, ap_done_d;

  logic w_fire, w_is_tap, r_is_tap, eng_owns, start_req;

  assign w_fire    = (w_state_q == W_RESP);
  assign w_is_tap  = (awaddr >= TAP_BASE) && (awaddr < TAP_END);
  assign r_is_tap  = (araddr >= TAP_BASE) && (araddr < TAP_END);
  assign eng_owns  = (c_state_q != C_IDLE);
  assign start_req = w_fire && (awaddr == ADDR_CTRL) && wdata[0] && !eng_owns;

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (awvalid && wvalid) w_state_d = W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end

  // A pending write in W_IDLE wins over a read arriving in the same cycle
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    tap_rd_d  = tap_rd_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && !(w_state_q == W_IDLE && awvalid && wvalid)) r_state_d = R_ADDR;
      end
      R_ADDR: begin
        raddr_d   = araddr;
        tap_rd_d  = r_is_tap && !eng_owns;
        r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (raddr_q == ADDR_CTRL) begin
          rdata_d = pDATA_WIDTH'({c_state_q == C_IDLE, ap_done_q, c_state_q == C_START});
        end else if (raddr_q == ADDR_DLEN) begin
          rdata_d = data_length_q;
        end else if (raddr_q == ADDR_TNUM) begin
          rdata_d = tap_num_q;
        end else if ((raddr_q >= TAP_BASE) && (raddr_q < TAP_END)) begin
          rdata_d = tap_rd_q ? tap_Do : '1;
        end else begin
          rdata_d = '0;
        end
        r_state_d = R_DATA;
      end
      R_DATA:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    c_state_d = c_state_q;
    case (c_state_q)
      C_IDLE:  if (start_req) c_state_d = C_START;
      C_START: c_state_d = C_BUSY;
      C_BUSY:  if (eng_done) c_state_d = C_IDLE;
      default: c_state_d = C_IDLE;
    endcase
  end

  // Completion from the engine takes precedence over a read-clear in the same cycle
  always_comb begin
    data_length_d = data_length_q;
    tap_num_d     = tap_num_q;
    ap_done_d     = ap_done_q;
    if (w_fire && !eng_owns) begin
      if (awaddr == ADDR_DLEN) data_length_d = wdata;
      if (awaddr == ADDR_TNUM) tap_num_d = (wdata > TAP_MAX) ? TAP_MAX : wdata;
    end
    if (r_state_q == R_DATA && rready && raddr_q == ADDR_CTRL) ap_done_d = 1'b0;
    if (start_req) ap_done_d = 1'b0;
    if (c_state_q == C_BUSY && eng_done) ap_done_d = 1'b1;
  end

  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (eng_owns) begin
      tap_EN = 1'b1;
      tap_A  = eng_tap_A;
    end else if (w_fire && w_is_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - TAP_BASE;
      tap_Di = wdata;
    end else if (r_state_q == R_ADDR && r_is_tap) begin
      tap_EN = 1'b1;
      tap_A  = araddr - TAP_BASE;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      w_state_q     <= W_IDLE;
      r_state_q     <= R_IDLE;
      c_state_q     <= C_IDLE;
      raddr_q       <= '0;
      tap_rd_q      <= 1'b0;
      rdata_q       <= '0;
      data_length_q <= '0;
      tap_num_q     <= TAP_MAX;
      ap_done_q     <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      r_state_q     <= r_state_d;
      c_state_q     <= c_state_d;
      raddr_q       <= raddr_d;
      tap_rd_q      <= tap_rd_d;
      rdata_q       <= rdata_d;
      data_length_q <= data_length_d;
      tap_num_q     <= tap_num_d;
      ap_done_q     <= ap_done_d;
    end
  end

  assign awready     = w_fire;
  assign wready      = w_fire;
  assign arready     = (r_state_q == R_ADDR);
  assign rvalid      = (r_state_q == R_DATA);
  assign rdata       = rdata_q;
  assign ap_start    = (c_state_q == C_START);
  assign data_length = data_length_q;
  assign tap_num     = tap_num_q;

endmodule

// File: doc/fir_axil_ctrl.md
# fir_axil_ctrl

Parametrised AXI-lite configuration and control slave for the FIR engine. Decodes an address map of control/status, data-length, tap-count and tap-coefficient registers; tap coefficients live in the external tap SRAM. Implements ap_start/ap_done/ap_idle block-level control and hands the SRAM over to the engine while a run is active. Sits between the PS AXI-lite master and the FIR datapath/tap SRAM.

## Interface
- pADDR_WIDTH, 12, AXI-lite and tap SRAM address width
- pDATA_WIDTH, 32, AXI-lite data and coefficient width
- Tape_Num, 11, maximum tap count (SRAM depth in words)
- axis_clk  in  1  sole clock, all logic on rising edge
- axis_rst_n  in  1  reset, asynchronous, active-low
- awvalid/awready  in/out  1  write address handshake
- awaddr  in  pADDR_WIDTH  write byte address
- wvalid/wready  in/out  1  write data handshake
- wdata  in  pDATA_WIDTH  write data
- arvalid/arready  in/out  1  read address handshake
- araddr  in  pADDR_WIDTH  read byte address
- rvalid/rready  out/in  1  read data handshake
- rdata  out  pDATA_WIDTH  read data
- tap_WE  out  4  SRAM byte write enables
- tap_EN  out  1  SRAM enable
- tap_Di  out  pDATA_WIDTH  SRAM write data
- tap_A  out  pADDR_WIDTH  SRAM byte address
- tap_Do  in  pDATA_WIDTH  SRAM read data, valid 1 cycle after tap_EN
- eng_tap_A  in  pADDR_WIDTH  engine SRAM read address, used only while busy
- ap_start  out  1  one-cycle start pulse to engine
- eng_done  in  1  one-cycle pulse from engine, last output produced
- data_length  out  pDATA_WIDTH  samples per run
- tap_num  out  pDATA_WIDTH  active tap count

## Operation
- Address map: 0x00 ap_ctrl (bit0 ap_start, bit1 ap_done, bit2 ap_idle, rest 0); 0x10 data_length; 0x14 tap_num; 0x80+4*i tap i, i < Tape_Num. Unmapped writes dropped; unmapped reads return 0.
- Write FSM W_IDLE -> W_RESP -> W_IDLE: in W_IDLE with awvalid && wvalid both high, next cycle awready = wready = 1 for exactly one cycle and the write takes effect. Either valid alone: wait, no ready.
- Read FSM R_IDLE -> R_ADDR -> R_WAIT -> R_DATA: arvalid in R_IDLE -> arready one cycle (R_ADDR, address latched, SRAM read issued if tap); R_WAIT for SRAM latency; R_DATA holds rvalid and rdata stable until rready, then R_IDLE.
- Write and read arriving in the same cycle with both FSMs idle: write accepted first, read accepted the cycle after W_RESP.
- Tap write: in W_RESP tap_EN = 1, tap_WE = 4'hF, tap_A = awaddr - 0x80, tap_Di = wdata. Tap read: in R_ADDR tap_EN = 1, tap_WE = 0, tap_A = araddr - 0x80; tap_Do captured in R_WAIT. Otherwise tap_EN = 0, tap_WE = 0.
- tap_num write clamps: value > Tape_Num stores Tape_Num.
- Control FSM IDLE -> START -> BUSY -> IDLE. Write to 0x00 with wdata[0] = 1 in IDLE -> START: ap_start = 1 one cycle, ap_idle = 0, ap_done = 0. BUSY until eng_done; on eng_done ap_done = 1, ap_idle = 1, back to IDLE.
- ap_start write outside IDLE ignored; write to 0x00 with bit0 = 0 no effect.
- ap_done clears on completed read of 0x00 (rvalid && rready). eng_done in the same cycle: ap_done stays 1.
- START/BUSY: SRAM owned by engine, tap_EN = 1, tap_WE = 0, tap_A = eng_tap_A. Writes to 0x10, 0x14, taps accepted on the bus but dropped; tap reads return 0xFFFFFFFF without SRAM access; ap_ctrl/data_length/tap_num reads normal.

## Timing
- Reset values: awready, wready, arready, rvalid, ap_start, tap_EN = 0; tap_WE = 0; rdata, tap_Di, tap_A = 0; data_length = 0; tap_num = Tape_Num; ap_idle = 1, ap_done = 0. SRAM contents untouched.
- Reset mid-transaction: both AXI FSMs and control FSM return to idle immediately; in-flight transaction discarded, no ready/valid emitted.
- Write latency: ready 1 cycle after both valids. Read: arready 1 cycle after arvalid, rvalid 2 cycles after arready.
- Ready/valid outputs all registered; no combinational path valid -> ready.

## Test plan
- Reset -> read 0x00 returns 0x4, read 0x14 returns 11, read 0x10 returns 0.
- Write taps 0..10 = 0,-10,-9,23,56,63,56,23,-9,-10,0 -> read-back identical; tap_A for tap 5 = 0x14.
- Write 0x14 = 20 -> read returns 11; write awvalid then wvalid 3 cycles later -> awready/wready only after wvalid.
- Write 0x00 = 1 -> ap_start pulse 1 cycle, read 0x00 = 0x0; tap 3 read returns 0xFFFFFFFF; write tap 3 = 99 dropped; eng_done -> read 0x00 = 0x6, second read = 0x4, tap 3 still 23.
- Write 0x00 = 1 while BUSY -> no second ap_start pulse; eng_done coincident with 0x00 read completion -> ap_done remains 1.
- Simultaneous aw/w and ar in idle -> write completes first; assert axis_rst_n low during R_WAIT -> rvalid never asserted, ap_idle = 1.
